uart_tx_serializer: RTL and testbench

- Parallel-to-serial UART transmitter; the upstream counterpart of UART_Rx.
- Runs on the same oversampled clock as the receiver, so one frame bit lasts Prescale clock cycles.
- Accepts a byte on a valid strobe and drives frames onto the line: start bit, LSB-first data, optional parity, stop bit.
- TX_OUT connects directly to UART_Rx RX_IN for loopback verification.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_bit_timer.sv | 32 +++
 rtl/uart_tx_serializer.sv | 107 ++++++++++
 tb/tb_uart_tx_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encoding, parity selectors,
// line idle level and default widths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN      = 1'b0;
  localparam logic PAR_ODD       = 1'b1;
  localparam logic TX_IDLE_LEVEL = 1'b1;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 6;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter; the bit length is captured on clear so a frame keeps
// its timing even if the prescale input moves underneath it.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] cycle_cnt;
  logic [PRESCALE_WIDTH-1:0] last_cnt;

  assign bit_done = enable && (cycle_cnt == last_cnt);

  // Terminal count is stored as P-1; prescale 0 collapses to a 1-cycle bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      last_cnt  <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
      last_cnt  <= (prescale == '0) ? '0 : prescale - 1'b1;
    end else if (enable) begin
      cycle_cnt <= bit_done ? '0 : cycle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, stop bit,
// each bit held for Prescale clock cycles of the oversampled clock.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  par_en_q;
  logic                  parity_q;
  logic                  bit_done;
  logic                  accept;
  logic                  timer_en;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  // A new byte is taken when idle, or on the final stop cycle for gapless frames.
  assign accept   = Data_Valid && ((state == IDLE) || ((state == STOP) && bit_done));
  assign timer_en = (state != IDLE);

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (accept),
    .enable  (timer_en),
    .prescale(Prescale),
    .bit_done(bit_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      TX_OUT   <= TX_IDLE_LEVEL;
      Busy     <= 1'b0;
    end else if (accept) begin
      state    <= START;
      shift_q  <= P_DATA;
      bit_cnt  <= '0;
      par_en_q <= PAR_EN;
      parity_q <= calc_parity(P_DATA, PAR_TYP);
      TX_OUT   <= 1'b0;
      Busy     <= 1'b1;
    end else if (bit_done) begin
      case (state)
        START: begin
          state  <= DATA;
          TX_OUT <= shift_q[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= parity_q;
            end else begin
              state  <= STOP;
              TX_OUT <= TX_IDLE_LEVEL;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift_q <= shift_q >> 1;
            TX_OUT  <= shift_q[1];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= TX_IDLE_LEVEL;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= TX_IDLE_LEVEL;
          Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= TX_IDLE_LEVEL;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: line waveform compared cycle by cycle against a
// frame model, plus a mid-bit sampling receiver decoding each frame.
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic model_parity(input logic [7:0] d, input logic pt);
    return logic'(($countones(d) % 2) != 0) ^ pt;
  endfunction

  // Line level i cycles after the start bit began
  function automatic logic exp_level(input logic [7:0] d, input logic pe, input logic pt,
                                     input int p, input int i);
    int idx;
    idx = i / p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pe && idx == 9) return model_parity(d, pt);
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] presc);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = presc; Data_Valid = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic watch_frame(input logic [7:0] d, input logic pe, input logic pt, input int p,
                             input logic keep_dv, input logic [7:0] next_d,
                             input int poke_cyc, input logic [5:0] poke_presc,
                             output logic [7:0] rx_d, output logic rx_par, output logic rx_stop);
    int   f;
    int   idx;
    logic lvl;
    f = (10 + int'(pe)) * p;
    rx_d = '0; rx_par = 1'b0; rx_stop = 1'b0;
    for (int i = 0; i < f; i++) begin
      lvl = exp_level(d, pe, pt, p, i);
      n_vec++;
      if (TX_OUT !== lvl) begin
        n_err++;
        $display("FAIL tx_out cyc=%0d data=%h p=%0d: got %b want %b", i, d, p, TX_OUT, lvl);
      end
      n_vec++;
      if (Busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy cyc=%0d data=%h p=%0d: got %b want 1", i, d, p, Busy);
      end
      if ((i % p) == (p / 2)) begin
        idx = i / p;
        if (idx >= 1 && idx <= 8) rx_d[idx-1] = TX_OUT;
        else if (pe && idx == 9) rx_par = TX_OUT;
        else if (idx != 0) rx_stop = TX_OUT;
      end
      Data_Valid = keep_dv;
      if (keep_dv && i == f - 1) P_DATA = next_d;
      if (i == poke_cyc) begin
        Data_Valid = 1'b1; P_DATA = 8'hFF; Prescale = poke_presc; PAR_EN = ~pe;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_loopback(input logic [7:0] d, input logic pe, input logic pt,
                                input logic [7:0] rx_d, input logic rx_par, input logic rx_stop);
    n_vec++;
    if (rx_d !== d) begin
      n_err++;
      $display("FAIL rx_data: got %h want %h", rx_d, d);
    end
    if (pe) begin
      n_vec++;
      if (rx_par !== model_parity(d, pt)) begin
        n_err++;
        $display("FAIL rx_parity data=%h: got %b want %b", d, rx_par, model_parity(d, pt));
      end
    end
    n_vec++;
    if (rx_stop !== 1'b1) begin
      n_err++;
      $display("FAIL rx_stop data=%h: got %b want 1", d, rx_stop);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle cyc=%0d: tx=%b busy=%b want tx=1 busy=0", i, TX_OUT, Busy);
      end
      Data_Valid = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  task automatic frame_test(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] presc, input int p,
                            input int poke_cyc, input logic [5:0] poke_presc);
    logic [7:0] rd;
    logic       rp, rs;
    start_frame(d, pe, pt, presc);
    watch_frame(d, pe, pt, p, 1'b0, 8'h00, poke_cyc, poke_presc, rd, rp, rs);
    check_loopback(d, pe, pt, rd, rp, rs);
    check_idle(2 * p);
  endtask

  task automatic test_reset();
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
    end
    Data_Valid = 1'b0; RST = 1'b0;
    @(posedge CLK); #1;
    check_idle(4);
  endtask

  task automatic test_basic();
    frame_test(8'h99, 1'b0, 1'b0, 6'd8, 8, -1, 6'd0);
  endtask

  task automatic test_parity();
    logic [7:0] rd;
    logic       rp, rs;
    logic [7:0] dv [3] = '{8'h99, 8'h99, 8'h55};
    logic       tv [3] = '{1'b0, 1'b1, 1'b0};
    logic       want [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      start_frame(dv[k], 1'b1, tv[k], 6'd8);
      watch_frame(dv[k], 1'b1, tv[k], 8, 1'b0, 8'h00, -1, 6'd0, rd, rp, rs);
      check_loopback(dv[k], 1'b1, tv[k], rd, rp, rs);
      n_vec++;
      if (rp !== want[k]) begin
        n_err++;
        $display("FAIL parity_bit data=%h typ=%b: got %b want %b", dv[k], tv[k], rp, want[k]);
      end
      check_idle(16);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd1, rd2;
    logic       rp1, rs1, rp2, rs2;
    start_frame(8'h99, 1'b0, 1'b0, 6'd8);
    watch_frame(8'h99, 1'b0, 1'b0, 8, 1'b1, 8'h55, -1, 6'd0, rd1, rp1, rs1);
    watch_frame(8'h55, 1'b0, 1'b0, 8, 1'b0, 8'h00, -1, 6'd0, rd2, rp2, rs2);
    check_loopback(8'h99, 1'b0, 1'b0, rd1, rp1, rs1);
    check_loopback(8'h55, 1'b0, 1'b0, rd2, rp2, rs2);
    check_idle(16);
  endtask

  task automatic test_busy_reject();
    frame_test(8'h99, 1'b0, 1'b0, 6'd8, 8, 20, 6'd4);
    check_idle(24);
  endtask

  task automatic test_reset_mid();
    start_frame(8'h99, 1'b0, 1'b0, 6'd8);
    for (int i = 0; i < 34; i++) begin
      n_vec++;
      if (TX_OUT !== exp_level(8'h99, 1'b0, 1'b0, 8, i)) begin
        n_err++;
        $display("FAIL pre_reset cyc=%0d: got %b want %b", i, TX_OUT, exp_level(8'h99, 1'b0, 1'b0, 8, i));
      end
      Data_Valid = 1'b0;
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    n_vec++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    frame_test(8'hA5, 1'b0, 1'b0, 6'd8, 8, -1, 6'd0);
  endtask

  task automatic test_prescale_sweep();
    int ps [3] = '{4, 16, 32};
    for (int k = 0; k < 3; k++)
      frame_test(8'h99, 1'b1, 1'b0, 6'(ps[k]), ps[k], 3 * ps[k] + 1, 6'(ps[(k + 1) % 3]));
  endtask

  task automatic test_random();
    int ps [4] = '{4, 8, 16, 32};
    int p;
    for (int k = 0; k < 6; k++) begin
      p = ps[$urandom_range(0, 3)];
      frame_test(8'($urandom), 1'($urandom), 1'($urandom), 6'(p), p, -1, 6'd0);
    end
    frame_test(8'($urandom), 1'b1, 1'b1, 6'd0, 1, -1, 6'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    test_prescale_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
